// File: rtl/fetch_sequencer.sv
// Program sequencer: owns the PC, fetches 16-bit instructions over req/ack, and splits them into fields.
// Optional HALT_DETECT_EN: a taken jump to the current pc parks the sequencer in HALT until reset.
module fetch_sequencer #(
    parameter int                  PC_WIDTH = 8,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    output logic                instr_req,
    output logic [PC_WIDTH-1:0] instr_addr,
    input  logic                instr_ack,
    input  logic [15:0]         instr_data,
    input  logic                branch_select,
    input  logic                branch_cond,
    output logic [2:0]          command_group,
    output logic [2:0]          command,
    output logic [4:0]          arg_a,
    output logic [4:0]          arg_b,
    output logic                exec_valid,
    output logic [PC_WIDTH-1:0] pc,
    output logic                halted,
    output logic [1:0]          dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [15:0]         ir_q, ir_d;
    logic                req_q, req_d;
    logic                ev_q, ev_d;
    logic                halted_q, halted_d;

    logic                jump_taken;
    logic [PC_WIDTH-1:0] jump_target;

    assign jump_taken  = branch_select & branch_cond;
    assign jump_target = ir_q[PC_WIDTH-1:0];

    // Handshake: a word transfers on any edge where instr_req and instr_ack are both high;
    // instr_req stays high with a stable instr_addr until that edge, and ack elsewhere is ignored.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        req_d    = 1'b0;
        ev_d     = 1'b0;
        halted_d = halted_q;
        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_FETCH;
                    req_d   = 1'b1;
                end
            end
            S_FETCH: begin
                if (instr_ack) begin
                    ir_d    = instr_data;
                    state_d = S_EXEC;
                    ev_d    = 1'b1;
                end else begin
                    req_d = 1'b1;
                end
            end
            S_EXEC: begin
                if (jump_taken) pc_d = jump_target;
                else            pc_d = pc_q + PC_WIDTH'(1);
`ifdef HALT_DETECT_EN
                if (jump_taken && (jump_target == pc_q)) begin
                    state_d  = S_HALT;
                    halted_d = 1'b1;
                    pc_d     = pc_q;
                end else
`endif
                if (run) begin
                    state_d = S_FETCH;
                    req_d   = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            ir_q     <= 16'h0000;
            req_q    <= 1'b0;
            ev_q     <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            req_q    <= req_d;
            ev_q     <= ev_d;
            halted_q <= halted_d;
        end
    end

    assign instr_req     = req_q;
    assign instr_addr    = pc_q;
    assign pc            = pc_q;
    assign exec_valid    = ev_q;
    assign halted        = halted_q;
    assign command_group = ir_q[15:13];
    assign command       = ir_q[12:10];
    assign arg_a         = ir_q[9:5];
    assign arg_b         = ir_q[4:0];
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: the bench plays program memory and the controller.
module tb_fetch_sequencer;

    logic       clk;
    logic       reset;
    logic       run;
    logic       instr_req;
    logic [7:0] instr_addr;
    logic       instr_ack;
    logic [15:0] instr_data;
    logic       branch_select;
    logic       branch_cond;
    logic [2:0] command_group;
    logic [2:0] command;
    logic [4:0] arg_a;
    logic [4:0] arg_b;
    logic       exec_valid;
    logic [7:0] pc;
    logic       halted;
    logic [1:0] dbg_state;

    int total = 0;
    int bad   = 0;

    fetch_sequencer #(.PC_WIDTH(8), .RESET_PC(8'h00)) dut (
        .clk(clk), .reset(reset), .run(run),
        .instr_req(instr_req), .instr_addr(instr_addr),
        .instr_ack(instr_ack), .instr_data(instr_data),
        .branch_select(branch_select), .branch_cond(branch_cond),
        .command_group(command_group), .command(command),
        .arg_a(arg_a), .arg_b(arg_b),
        .exec_valid(exec_valid), .pc(pc), .halted(halted),
        .dbg_state(dbg_state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // state of a FETCH cycle: req high, given address, no strobe
    task automatic chk_fetch(input string tag, input logic [7:0] addr);
        chk({tag, "_req"}, 32'(instr_req), 32'd1);
        chk({tag, "_addr"}, 32'(instr_addr), 32'(addr));
        chk({tag, "_ev"}, 32'(exec_valid), 32'd0);
    endtask

    task automatic chk_exec(input string tag, input logic [7:0] exp_pc, input logic [15:0] word);
        chk({tag, "_ev"}, 32'(exec_valid), 32'd1);
        chk({tag, "_req"}, 32'(instr_req), 32'd0);
        chk({tag, "_pc"}, 32'(pc), 32'(exp_pc));
        chk({tag, "_fields"}, {16'h0, command_group, command, arg_a, arg_b}, {16'h0, word});
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; instr_ack = 1'b0; instr_data = 16'h0000;
        branch_select = 1'b0; branch_cond = 1'b0;
        #3;
        chk("rst_req", 32'(instr_req), 32'd0);
        chk("rst_ev", 32'(exec_valid), 32'd0);
        chk("rst_pc", 32'(pc), 32'h00);
        chk("rst_fields", {16'h0, command_group, command, arg_a, arg_b}, 32'h0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'd0);
        tick();
        reset = 1'b0; run = 1'b1;

        // first fetch at 0, zero-wait ack with A5C3
        tick();
        chk_fetch("f0", 8'h00);
        instr_ack = 1'b1; instr_data = 16'hA5C3;
        tick();
        chk_exec("e0", 8'h00, 16'hA5C3);
        chk("e0_group", 32'(command_group), 32'd5);
        chk("e0_cmd", 32'(command), 32'd1);
        chk("e0_arga", 32'(arg_a), 32'h0E);
        chk("e0_argb", 32'(arg_b), 32'h03);
        instr_data = 16'h0000;
        tick();
        chk_fetch("f1", 8'h01);
        chk("f1_hold_fields", {16'h0, command_group, command, arg_a, arg_b}, 32'h0000A5C3);
        tick();
        chk_exec("e1", 8'h01, 16'h0000);
        tick();
        chk_fetch("f2", 8'h02);

        // taken jump to 2A, then untaken jump condition
        instr_data = 16'h002A;
        tick();
        chk_exec("e2", 8'h02, 16'h002A);
        branch_select = 1'b1; branch_cond = 1'b1;
        tick();
        chk_fetch("f_jmp", 8'h2A);
        branch_select = 1'b0; branch_cond = 1'b0;
        tick();
        chk_exec("e_2a", 8'h2A, 16'h002A);
        branch_select = 1'b1; branch_cond = 1'b0;
        tick();
        chk_fetch("f_nojmp", 8'h2B);

        // jump to FF, then non-jump wraps to 00
        branch_select = 1'b0; instr_data = 16'h00FF;
        tick();
        chk_exec("e_2b", 8'h2B, 16'h00FF);
        branch_select = 1'b1; branch_cond = 1'b1;
        tick();
        chk_fetch("f_ff", 8'hFF);
        branch_select = 1'b0; branch_cond = 1'b0; instr_data = 16'h1234;
        tick();
        chk_exec("e_ff", 8'hFF, 16'h1234);
        instr_ack = 1'b0;
        tick();
        chk_fetch("f_wrap", 8'h00);

        // ack delayed three cycles: req held four cycles
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_fetch("f_wait", 8'h00);
        end
        instr_ack = 1'b1; instr_data = 16'h4C21;
        tick();
        chk_exec("e_wait", 8'h00, 16'h4C21);
        chk("e_wait_group", 32'(command_group), 32'd2);
        chk("e_wait_cmd", 32'(command), 32'd3);
        instr_ack = 1'b0;
        tick();
        chk_fetch("f_after_wait", 8'h01);

        // run dropped during FETCH: fetch and EXEC complete, then IDLE
        run = 1'b0;
        tick();
        chk_fetch("f_norun", 8'h01);
        instr_ack = 1'b1; instr_data = 16'h0000;
        tick();
        chk_exec("e_norun", 8'h01, 16'h0000);
        tick();
        chk("idle_req", 32'(instr_req), 32'd0);
        chk("idle_ev", 32'(exec_valid), 32'd0);
        chk("idle_pc", 32'(pc), 32'h02);
        chk("idle_state", 32'(dbg_state), 32'd0);
        tick();
        chk("idle_ack_ignored_req", 32'(instr_req), 32'd0);
        chk("idle_ack_ignored_ev", 32'(exec_valid), 32'd0);
        instr_ack = 1'b0;

        // reset mid-FETCH: req drops without a clock edge
        run = 1'b1;
        tick();
        chk_fetch("f_prerst", 8'h02);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_mid_req", 32'(instr_req), 32'd0);
        chk("rst_mid_pc", 32'(pc), 32'h00);
        tick();
        reset = 1'b0;
        tick();
        chk_fetch("f_postrst", 8'h00);

        // self-jump at 10
        instr_ack = 1'b1; instr_data = 16'h0010;
        tick();
        chk_exec("e_to10", 8'h00, 16'h0010);
        branch_select = 1'b1; branch_cond = 1'b1;
        tick();
        chk_fetch("f_10", 8'h10);
        tick();
        chk_exec("e_self", 8'h10, 16'h0010);
        tick();
`ifdef HALT_DETECT_EN
        chk("halt_flag", 32'(halted), 32'd1);
        chk("halt_req", 32'(instr_req), 32'd0);
        chk("halt_ev", 32'(exec_valid), 32'd0);
        chk("halt_pc", 32'(pc), 32'h10);
        tick();
        tick();
        chk("halt_stay_req", 32'(instr_req), 32'd0);
        chk("halt_stay_flag", 32'(halted), 32'd1);
`else
        chk_fetch("f_self1", 8'h10);
        chk("nohalt_flag", 32'(halted), 32'd0);
        tick();
        chk_exec("e_self2", 8'h10, 16'h0010);
        tick();
        chk_fetch("f_self2", 8'h10);
        chk("nohalt_flag2", 32'(halted), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
